// File: rtl/reg_file_bank.sv
// reg_file_bank: 32 x DATA_W MIPS general-purpose register storage.
// Takes one writeback write per cycle and exposes every register as a flat
// bus for the two read-port muxes. Register 0 is hard-wired to zero. The block
// also tracks which registers have been written since reset, counts accepted
// writes with saturation, and flags writes that were aimed at $zero.
module reg_file_bank #(
    parameter int               DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [DATA_W-1:0] GP_RESET = 32'h1000_8000,
    parameter bit               BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [32*DATA_W-1:0]  regs_flat,
    output logic [31:0]           written,
    output logic [15:0]           wr_count,
    output logic                  zero_wr
);

    localparam int NUM_REGS = 32;
    localparam int SP_IDX   = 29;
    localparam int GP_IDX   = 28;

    // Architectural reset value of a register: $gp and $sp start at the
    // conventional MIPS memory-map locations, everything else clears.
    function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if (idx == 5'(GP_IDX)) begin
            val = GP_RESET;
        end else if (idx == 5'(SP_IDX)) begin
            val = SP_RESET;
        end
        return val;
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of
    // wrapping, so a long-running count never reads as small again.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        logic [15:0] nxt;
        nxt = cnt;
        if (cnt != 16'hFFFF) begin
            nxt = cnt + 16'd1;
        end
        return nxt;
    endfunction

    // Qualified write requests. Gating by we first keeps X on waddr/wdata
    // from leaking into state or the read view while the port is idle, and
    // gating by rst gives reset priority over a same-cycle write.
    logic wr_accept;
    logic zero_attempt;

    assign wr_accept    = we & ~rst & (waddr != 5'd0);
    assign zero_attempt = we & ~rst & (waddr == 5'd0);

    // One-hot write select; bit 0 can never be set, so $zero is never touched.
    logic [NUM_REGS-1:0] wr_sel;

    // Decode the destination index into a one-hot register select.
    always_comb begin
        wr_sel = '0;
        if (wr_accept) begin
            wr_sel[waddr] = 1'b1;
        end
    end

    // Storage for r1..r31; r0 has no flops since it always reads zero.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

    genvar k;
    generate
        for (k = 1; k < NUM_REGS; k++) begin : g_reg
            // Per-register storage: reset to its architectural value, else
            // load write data when selected.
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[k] <= reset_value(5'(k));
                end else if (wr_sel[k]) begin
                    regs_q[k] <= wdata;
                end
            end
        end
    endgenerate

    // Flat read view. Slice 0 is constant zero. With BYPASS set, the slice
    // being written this cycle shows the incoming data so a same-cycle
    // reader sees the new value; wr_sel already excludes reset cycles.
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_view
            if (k == 0) begin : g_zero
                assign regs_flat[DATA_W-1:0] = '0;
            end else if (BYPASS) begin : g_bypass
                assign regs_flat[k*DATA_W +: DATA_W] = wr_sel[k] ? wdata : regs_q[k];
            end else begin : g_stored
                assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
            end
        end
    endgenerate

    // Written-since-reset tracker: bits accumulate and only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else begin
            written <= written | wr_sel;
        end
    end

    // Accepted-write counter, saturating at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_accept) begin
            wr_count <= sat_inc(wr_count);
        end
    end

    // One-cycle flag following any attempted write to $zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_wr <= 1'b0;
        end else begin
            zero_wr <= zero_attempt;
        end
    end

endmodule
